// File: rtl/alu_share_arbiter_if.sv
// Bundle of signals between the two requesters, the shared ALU and the result
// consumer. The arbiter takes the slave view. The environment (requesters, ALU
// and consumer together) takes the master view.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
);
    logic             req0;
    logic [OP_W-1:0]  ctrl0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             gnt0;

    logic             req1;
    logic [OP_W-1:0]  ctrl1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt1;

    logic [OP_W-1:0]  alu_control;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_rslt;
    logic             alu_zero;

    logic             out_valid;
    logic             out_id;
    logic [WIDTH-1:0] out_rslt;
    logic             out_zero;
    logic             out_ready;

    modport master (
        output req0, ctrl0, a0, b0,
        output req1, ctrl1, a1, b1,
        output alu_rslt, alu_zero, out_ready,
        input  gnt0, gnt1,
        input  alu_control, alu_a, alu_b,
        input  out_valid, out_id, out_rslt, out_zero
    );

    modport slave (
        input  req0, ctrl0, a0, b0,
        input  req1, ctrl1, a1, b1,
        input  alu_rslt, alu_zero, out_ready,
        output gnt0, gnt1,
        output alu_control, alu_a, alu_b,
        output out_valid, out_id, out_rslt, out_zero
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters. The
// winning port drives the ALU in the grant cycle. The ALU result is captured
// one cycle later in an output register with a valid/ready handshake.
module alu_share_arbiter #(
    parameter int WIDTH      = 32,
    parameter int OP_W       = 4,
    parameter int PRIO_RESET = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   bus
);
    // last_win starts on the port opposite PRIO_RESET, so the first tie goes
    // to PRIO_RESET.
    localparam logic LAST_WIN_RST = (PRIO_RESET == 0);

    logic             can_accept;
    logic             sel1;
    logic             gnt0;
    logic             gnt1;
    logic             last_win;

    logic             vld_p1;
    logic             id_p1;
    logic             zero_p1;
    logic [WIDTH-1:0] rslt_p1;

    // Stage 0: arbitration. A new op is accepted only if the output register
    // is free or is being drained in this cycle.
    always_comb begin
        can_accept = 1'b0;
        sel1       = 1'b0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        can_accept = !rst && (!vld_p1 || bus.out_ready);
        if (bus.req0 && bus.req1) begin
            sel1 = !last_win;
        end else begin
            sel1 = bus.req1;
        end
        gnt0 = can_accept && bus.req0 && !sel1;
        gnt1 = can_accept && bus.req1 && sel1;
    end

    // Drive the shared ALU from the granted port. Drive zeros when idle.
    always_comb begin
        bus.alu_control = '0;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        if (gnt0) begin
            bus.alu_control = bus.ctrl0;
            bus.alu_a       = bus.a0;
            bus.alu_b       = bus.b0;
        end else if (gnt1) begin
            bus.alu_control = bus.ctrl1;
            bus.alu_a       = bus.a1;
            bus.alu_b       = bus.b1;
        end
    end

    // Stage 1: capture the ALU result. A grant overwrites a result that is
    // being consumed in the same cycle. This allows one op per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            id_p1    <= 1'b0;
            rslt_p1  <= '0;
            zero_p1  <= 1'b0;
            last_win <= LAST_WIN_RST;
        end else if (gnt0 || gnt1) begin
            vld_p1   <= 1'b1;
            id_p1    <= gnt1;
            rslt_p1  <= bus.alu_rslt;
            zero_p1  <= bus.alu_zero;
            last_win <= gnt1;
        end else if (vld_p1 && bus.out_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.out_valid = vld_p1;
    assign bus.out_id    = id_p1;
    assign bus.out_rslt  = rslt_p1;
    assign bus.out_zero  = zero_p1;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter. A small combinational ALU stands in
// for the shared unit. Per-cycle vectors carry hand-computed grants and
// output-register contents.
module tb_alu_share_arbiter;
    logic clk;
    logic rst;

    alu_share_arbiter_if #(.WIDTH(32), .OP_W(4)) bus ();

    alu_share_arbiter #(.WIDTH(32), .OP_W(4), .PRIO_RESET(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU. Code 0 adds, 1 subtracts, 2 shifts b left by a,
    // 3 ANDs, 4 ORs, 5 shifts b right by a, 6 is a signed a<b test and
    // 7 XORs. Codes 8 to 15 give 0.
    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (c)
            4'd0: alu_f = a + b;
            4'd1: alu_f = a - b;
            4'd2: alu_f = b << a[4:0];
            4'd3: alu_f = a & b;
            4'd4: alu_f = a | b;
            4'd5: alu_f = b >> a[4:0];
            4'd6: alu_f = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: alu_f = a ^ b;
            default: alu_f = 32'd0;
        endcase
    endfunction

    assign bus.alu_rslt = alu_f(bus.alu_control, bus.alu_a, bus.alu_b);
    assign bus.alu_zero = (bus.alu_rslt == 32'd0);

    typedef struct {
        logic        rst;
        logic        r0;
        logic [3:0]  c0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic        r1;
        logic [3:0]  c1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic        rdy;
        logic        eg0;
        logic        eg1;
        logic        ev;
        logic        eid;
        logic [31:0] er;
        logic        ez;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;

    task automatic add(input logic rs, input logic r0, input logic [3:0] c0, input logic [31:0] a0,
                       input logic [31:0] b0, input logic r1, input logic [3:0] c1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic rdy, input logic eg0, input logic eg1,
                       input logic ev, input logic eid, input logic [31:0] er, input logic ez);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.c0 = c0; v.a0 = a0; v.b0 = b0;
        v.r1 = r1; v.c1 = c1; v.a1 = a1; v.b1 = b1; v.rdy = rdy;
        v.eg0 = eg0; v.eg1 = eg1; v.ev = ev; v.eid = eid; v.er = er; v.ez = ez;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic r0, input logic [3:0] c0, input logic [31:0] a0,
                         input logic [31:0] b0, input logic r1, input logic [3:0] c1, input logic [31:0] a1,
                         input logic [31:0] b1, input logic rdy);
        rst = rs;
        bus.req0 = r0; bus.ctrl0 = c0; bus.a0 = a0; bus.b0 = b0;
        bus.req1 = r1; bus.ctrl1 = c1; bus.a1 = a1; bus.b1 = b1;
        bus.out_ready = rdy;
    endtask

    initial begin
        vec_t v;
        logic [3:0]  ec;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        exp_g1;

        checks   = 0;
        failures = 0;

        // rst r0 c0 a0 b0 | r1 c1 a1 b1 | rdy | g0 g1 | v id rslt z
        // Reset with port 0 requesting: no grant, registers cleared.
        add(1, 1, 4'h0, 32'd5, 32'd7, 0, 4'h0, 32'd0, 32'd0, 1, 0, 0, 0, 0, 32'd0, 0);
        // Single add, 5+7.
        add(0, 1, 4'h0, 32'd5, 32'd7, 0, 4'h0, 32'd0, 32'd0, 1, 1, 0, 1, 0, 32'd12, 0);
        // Reset again so the tie below starts from reset priority.
        add(1, 1, 4'h1, 32'd3, 32'd3, 1, 4'h7, 32'hF0, 32'h0F, 1, 0, 0, 0, 0, 32'd0, 0);
        // Tie goes to port 0 first, then port 1.
        add(0, 1, 4'h1, 32'd3, 32'd3, 1, 4'h7, 32'hF0, 32'h0F, 1, 1, 0, 1, 0, 32'd0, 1);
        add(0, 0, 4'h0, 32'd0, 32'd0, 1, 4'h7, 32'hF0, 32'h0F, 1, 0, 1, 1, 1, 32'hFF, 0);
        // Backpressure for 3 cycles with both requesting.
        add(0, 1, 4'h0, 32'd1, 32'd1, 1, 4'h3, 32'hC, 32'hA, 0, 0, 0, 1, 1, 32'hFF, 0);
        add(0, 1, 4'h0, 32'd1, 32'd1, 1, 4'h3, 32'hC, 32'hA, 0, 0, 0, 1, 1, 32'hFF, 0);
        add(0, 1, 4'h0, 32'd1, 32'd1, 1, 4'h3, 32'hC, 32'hA, 0, 0, 0, 1, 1, 32'hFF, 0);
        // Ready returns: consume and grant in the same cycle.
        add(0, 1, 4'h0, 32'd1, 32'd1, 1, 4'h3, 32'hC, 32'hA, 1, 1, 0, 1, 0, 32'd2, 0);
        add(0, 0, 4'h0, 32'd0, 32'd0, 1, 4'h3, 32'hC, 32'hA, 1, 0, 1, 1, 1, 32'd8, 0);
        // Port 1 streams alone: 1<<4 each cycle.
        add(0, 0, 4'h0, 32'd0, 32'd0, 1, 4'h2, 32'd4, 32'd1, 1, 0, 1, 1, 1, 32'd16, 0);
        add(0, 0, 4'h0, 32'd0, 32'd0, 1, 4'h2, 32'd4, 32'd1, 1, 0, 1, 1, 1, 32'd16, 0);
        add(0, 0, 4'h0, 32'd0, 32'd0, 1, 4'h2, 32'd4, 32'd1, 1, 0, 1, 1, 1, 32'd16, 0);
        add(0, 0, 4'h0, 32'd0, 32'd0, 1, 4'h2, 32'd4, 32'd1, 1, 0, 1, 1, 1, 32'd16, 0);
        // Signed compare, -1 < 1.
        add(0, 0, 4'h0, 32'd0, 32'd0, 1, 4'h6, 32'hFFFFFFFF, 32'd1, 1, 0, 1, 1, 1, 32'd1, 0);
        // Code 0xA gives zero.
        add(0, 1, 4'hA, 32'd9, 32'd9, 0, 4'h0, 32'd0, 32'd0, 1, 1, 0, 1, 0, 32'd0, 1);
        // Drain, then idle with no ready. The data registers hold.
        add(0, 0, 4'h0, 32'd0, 32'd0, 0, 4'h0, 32'd0, 32'd0, 1, 0, 0, 0, 0, 32'd0, 1);
        add(0, 0, 4'h0, 32'd0, 32'd0, 0, 4'h0, 32'd0, 32'd0, 0, 0, 0, 0, 0, 32'd0, 1);
        // Empty register accepts even without ready.
        add(0, 1, 4'h0, 32'd1, 32'd2, 0, 4'h0, 32'd0, 32'd0, 0, 1, 0, 1, 0, 32'd3, 0);
        // Full and stalled, then reset mid-operation.
        add(0, 1, 4'h0, 32'd1, 32'd2, 1, 4'h4, 32'h30, 32'h03, 0, 0, 0, 1, 0, 32'd3, 0);
        add(1, 1, 4'h0, 32'd1, 32'd2, 1, 4'h4, 32'h30, 32'h03, 0, 0, 0, 0, 0, 32'd0, 0);
        // First tie after reset goes to port 0.
        add(0, 1, 4'h0, 32'd1, 32'd2, 1, 4'h4, 32'h30, 32'h03, 0, 1, 0, 1, 0, 32'd3, 0);
        // Port 1 stalled, then drops its request before a grant.
        add(0, 0, 4'h0, 32'd0, 32'd0, 1, 4'h4, 32'h30, 32'h03, 0, 0, 0, 1, 0, 32'd3, 0);
        add(0, 0, 4'h0, 32'd0, 32'd0, 0, 4'h4, 32'h30, 32'h03, 1, 0, 0, 0, 0, 32'd3, 0);

        drive(1, 0, 4'h0, 32'd0, 32'd0, 0, 4'h0, 32'd0, 32'd0, 0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v.rst, v.r0, v.c0, v.a0, v.b0, v.r1, v.c1, v.a1, v.b1, v.rdy);
            #1;
            ec = v.eg0 ? v.c0 : (v.eg1 ? v.c1 : 4'h0);
            ea = v.eg0 ? v.a0 : (v.eg1 ? v.a1 : 32'd0);
            eb = v.eg0 ? v.b0 : (v.eg1 ? v.b1 : 32'd0);
            chk($sformatf("v%0d gnt0", i), 32'(bus.gnt0), 32'(v.eg0));
            chk($sformatf("v%0d gnt1", i), 32'(bus.gnt1), 32'(v.eg1));
            chk($sformatf("v%0d alu_control", i), 32'(bus.alu_control), 32'(ec));
            chk($sformatf("v%0d alu_a", i), bus.alu_a, ea);
            chk($sformatf("v%0d alu_b", i), bus.alu_b, eb);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(v.ev));
            chk($sformatf("v%0d out_id", i), 32'(bus.out_id), 32'(v.eid));
            chk($sformatf("v%0d out_rslt", i), bus.out_rslt, v.er);
            chk($sformatf("v%0d out_zero", i), 32'(bus.out_zero), 32'(v.ez));
        end

        // Both ports request on every cycle at full throughput. The last grant
        // went to port 0, so grants alternate starting with port 1.
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 4'h0, 32'd10, 32'd1, 1, 4'h0, 32'd20, 32'd2, 1);
            exp_g1 = (k % 2 == 0);
            #1;
            chk($sformatf("rr%0d gnt0", k), 32'(bus.gnt0), 32'(!exp_g1));
            chk($sformatf("rr%0d gnt1", k), 32'(bus.gnt1), 32'(exp_g1));
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d out_id", k), 32'(bus.out_id), 32'(exp_g1));
            chk($sformatf("rr%0d out_rslt", k), bus.out_rslt, exp_g1 ? 32'd22 : 32'd11);
        end

        drive(0, 0, 4'h0, 32'd0, 32'd0, 0, 4'h0, 32'd0, 32'd0, 1);
        @(posedge clk);
        #1;
        chk("drain out_valid", 32'(bus.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
